// File: rtl/writeback_regfile_pkg.sv
// writeback_regfile_pkg
//   Shared pipeline definitions for the EX->WB boundary: data width,
//   register-file geometry, register address type and the EX_WB pipeline
//   register layout produced by the execute stage.
package writeback_regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic            alu_result_ready;
        reg_addr_t       reg_wr_addr;
        logic            reg_wr_en;
        logic [XLEN-1:0] pc;
    } ex_wb_t;

endpackage

// File: rtl/writeback_regfile_regfile_2r1w.sv
// writeback_regfile_regfile_2r1w
//   Two-read / one-write integer register file with x0 hardwired to zero
//   and write-through bypass on both read ports.
//   Ports:
//     clk, reset_n        clock (rising edge), async active-low reset
//     wr_en/addr/data     write port; a write to x0 is ignored
//     rs1_addr, rs2_addr  read addresses
//     rs1_data, rs2_data  combinational read data (bypassed when the
//                         write port targets the same register)
import writeback_regfile_pkg::*;

module writeback_regfile_regfile_2r1w (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  reg_addr_t       wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wr_live && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wr_live && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Write-back stage: commits EX_WB results into the register file,
//   supplies the two ALU operands with same-cycle bypass, tracks pending
//   writes to raise a decode stall, and keeps retire bookkeeping.
//   Ports:
//     clk, reset_n            clock (rising edge), async active-low reset
//     ex_wb_reg               execute result pipeline register
//     rs1_addr/rs2_addr       operand read addresses
//     rs1_data/rs2_data       operand data
//     issue_valid/issue_rd/
//     issue_rd_wr_en          instruction leaving decode this cycle
//     stall                   operand hazard toward decode
//     wb_valid                one instruction retired last cycle
//     last_retired_pc         pc of the most recent retire
//     retired_count           retired-instruction counter (wraps)
import writeback_regfile_pkg::*;

module writeback_regfile #(
    parameter int unsigned RETIRE_CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  ex_wb_t                  ex_wb_reg,
    input  reg_addr_t               rs1_addr,
    input  reg_addr_t               rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    input  logic                    issue_valid,
    input  reg_addr_t               issue_rd,
    input  logic                    issue_rd_wr_en,
    output logic                    stall,
    output logic                    wb_valid,
    output logic [XLEN-1:0]         last_retired_pc,
    output logic [RETIRE_CNT_W-1:0] retired_count
);

    logic                retire;
    logic                commit;
    logic                sb_set;
    logic [NUM_REGS-1:0] busy;
    logic                rs1_hazard;
    logic                rs2_hazard;

    assign retire = ex_wb_reg.alu_result_ready;
    assign commit = retire && ex_wb_reg.reg_wr_en && (ex_wb_reg.reg_wr_addr != '0);
    assign sb_set = issue_valid && issue_rd_wr_en && (issue_rd != '0);

    writeback_regfile_regfile_2r1w u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (commit),
        .wr_addr  (ex_wb_reg.reg_wr_addr),
        .wr_data  (ex_wb_reg.alu_result),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    // Clear is written before set so that a same-register set/clear leaves
    // the bit set: the newly issued writer is still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (commit) begin
                busy[ex_wb_reg.reg_wr_addr] <= 1'b0;
            end
            if (sb_set) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    // A result committing this cycle is bypassed, so it does not stall.
    assign rs1_hazard = busy[rs1_addr] && !(commit && (ex_wb_reg.reg_wr_addr == rs1_addr));
    assign rs2_hazard = busy[rs2_addr] && !(commit && (ex_wb_reg.reg_wr_addr == rs2_addr));
    assign stall      = rs1_hazard || rs2_hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid        <= 1'b0;
            last_retired_pc <= '0;
            retired_count   <= '0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                last_retired_pc <= ex_wb_reg.pc;
                retired_count   <= retired_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
import writeback_regfile_pkg::*;

module tb_writeback_regfile;

    logic            clk;
    logic            reset_n;
    ex_wb_t          ex;
    reg_addr_t       rs1_addr;
    reg_addr_t       rs2_addr;
    logic [31:0]     rs1_data;
    logic [31:0]     rs2_data;
    logic            issue_valid;
    reg_addr_t       issue_rd;
    logic            issue_rd_wr_en;
    logic            stall;
    logic            wb_valid;
    logic [31:0]     last_retired_pc;
    logic [63:0]     retired_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [63:0] m_count;
    logic [31:0] m_pc;
    logic        m_wbv;

    writeback_regfile #(.RETIRE_CNT_W(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_wb_reg       (ex),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rd_wr_en  (issue_rd_wr_en),
        .stall           (stall),
        .wb_valid        (wb_valid),
        .last_retired_pc (last_retired_pc),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ex             = '0;
        rs1_addr       = '0;
        rs2_addr       = '0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_rd_wr_en = 1'b0;
    endtask

    task automatic set_ex(input logic rdy, input logic wen, input reg_addr_t wa,
                          input logic [31:0] res, input logic [31:0] pc);
        ex.alu_result_ready = rdy;
        ex.reg_wr_en        = wen;
        ex.reg_wr_addr      = wa;
        ex.alu_result       = res;
        ex.pc               = pc;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #12;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = reg_addr_t'(i);
            rs2_addr = reg_addr_t'(31 - i);
            #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got rs1=%h rs2=%h stall=%b want 0 0 0",
                         i, rs1_data, rs2_data, stall);
            end
        end
        checks++;
        if (retired_count !== 64'd0 || wb_valid !== 1'b0 || last_retired_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got count=%0d wbv=%b pc=%h want 0 0 0",
                     retired_count, wb_valid, last_retired_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        set_ex(1'b1, 1'b1, 5'd5, 32'h1234, 32'h40);
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'h1234) begin
            errors++; $display("FAIL bypass_rs1 got %h want 00001234", rs1_data);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'h1234 || wb_valid !== 1'b1 || last_retired_pc !== 32'h40 ||
            retired_count !== 64'd1) begin
            errors++;
            $display("FAIL commit_state got data=%h wbv=%b pc=%h cnt=%0d want 00001234 1 00000040 1",
                     rs1_data, wb_valid, last_retired_pc, retired_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || retired_count !== 64'd1) begin
            errors++;
            $display("FAIL wb_pulse got wbv=%b cnt=%0d want 0 1", wb_valid, retired_count);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        set_ex(1'b1, 1'b1, 5'd0, 32'hdeadbeef, 32'h44);
        rs1_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            errors++; $display("FAIL x0_before got %h want 0", rs1_data);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h0 || retired_count !== 64'd2 || last_retired_pc !== 32'h44) begin
            errors++;
            $display("FAIL x0_after got data=%h cnt=%0d pc=%h want 0 2 00000044",
                     rs1_data, retired_count, last_retired_pc);
        end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_wr_en = 1'b1;
        @(negedge clk);
        idle();
        rs2_addr = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL hazard_stall got %b want 1", stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL hazard_hold got %b want 1", stall);
        end
        set_ex(1'b1, 1'b1, 5'd7, 32'h77, 32'h48);
        #1;
        checks++;
        if (stall !== 1'b0 || rs2_data !== 32'h77) begin
            errors++;
            $display("FAIL hazard_commit got stall=%b data=%h want 0 00000077", stall, rs2_data);
        end
        @(negedge clk);
        idle();
        rs2_addr = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b0 || rs2_data !== 32'h77) begin
            errors++;
            $display("FAIL hazard_cleared got stall=%b data=%h want 0 00000077", stall, rs2_data);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3; issue_rd_wr_en = 1'b1;
        set_ex(1'b1, 1'b1, 5'd3, 32'h33, 32'h4c);
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b0 || rs1_data !== 32'h33) begin
            errors++;
            $display("FAIL setwins_same got stall=%b data=%h want 0 00000033", stall, rs1_data);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b1 || rs1_data !== 32'h33) begin
            errors++;
            $display("FAIL setwins_after got stall=%b data=%h want 1 00000033", stall, rs1_data);
        end
    endtask

    task automatic test_wrap_reset();
        @(negedge clk);
        force dut.retired_count = '1;
        #1;
        release dut.retired_count;
        #1;
        checks++;
        if (retired_count !== 64'hffff_ffff_ffff_ffff) begin
            errors++; $display("FAIL wrap_preload got %h want all ones", retired_count);
        end
        set_ex(1'b1, 1'b0, 5'd0, 32'h0, 32'h50);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (retired_count !== 64'd0 || wb_valid !== 1'b1 || last_retired_pc !== 32'h50) begin
            errors++;
            $display("FAIL wrap got cnt=%h wbv=%b pc=%h want 0 1 00000050",
                     retired_count, wb_valid, last_retired_pc);
        end
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rd_wr_en = 1'b1;
        @(negedge clk);
        idle();
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall got %b want 1", stall);
        end
        set_ex(1'b1, 1'b0, 5'd0, 32'h0, 32'h54);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || retired_count !== 64'd0 || wb_valid !== 1'b0 ||
            last_retired_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got stall=%b cnt=%0d wbv=%b pc=%h want 0 0 0 0",
                     stall, retired_count, wb_valid, last_retired_pc);
        end
        @(negedge clk);
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic        cm;
        logic [31:0] e1, e2;
        logic        es;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_count = '0; m_pc = '0; m_wbv = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            set_ex(($urandom_range(9) < 7), $urandom_range(1), reg_addr_t'($urandom_range(7)),
                   $urandom, $urandom);
            rs1_addr       = reg_addr_t'($urandom_range(15));
            rs2_addr       = reg_addr_t'($urandom_range(15));
            issue_valid    = ($urandom_range(1) == 1);
            issue_rd       = reg_addr_t'($urandom_range(7));
            issue_rd_wr_en = ($urandom_range(3) != 0);
            #1;
            cm = ex.alu_result_ready && ex.reg_wr_en && (ex.reg_wr_addr != 0);
            e1 = (rs1_addr == 0) ? 32'h0 :
                 (cm && ex.reg_wr_addr == rs1_addr) ? ex.alu_result : m_regs[rs1_addr];
            e2 = (rs2_addr == 0) ? 32'h0 :
                 (cm && ex.reg_wr_addr == rs2_addr) ? ex.alu_result : m_regs[rs2_addr];
            es = (m_busy[rs1_addr] && !(cm && ex.reg_wr_addr == rs1_addr)) ||
                 (m_busy[rs2_addr] && !(cm && ex.reg_wr_addr == rs2_addr));
            checks++;
            if (rs1_data !== e1 || rs2_data !== e2 || stall !== es) begin
                errors++;
                $display("FAIL rand_comb n=%0d got rs1=%h rs2=%h stall=%b want %h %h %b",
                         n, rs1_data, rs2_data, stall, e1, e2, es);
            end
            checks++;
            if (wb_valid !== m_wbv || last_retired_pc !== m_pc || retired_count !== m_count) begin
                errors++;
                $display("FAIL rand_retire n=%0d got wbv=%b pc=%h cnt=%0d want %b %h %0d",
                         n, wb_valid, last_retired_pc, retired_count, m_wbv, m_pc, m_count);
            end
            @(posedge clk);
            m_wbv = ex.alu_result_ready;
            if (ex.alu_result_ready) begin
                m_pc    = ex.pc;
                m_count = m_count + 64'd1;
            end
            if (cm) begin
                m_regs[ex.reg_wr_addr] = ex.alu_result;
                m_busy[ex.reg_wr_addr] = 1'b0;
            end
            if (issue_valid && issue_rd_wr_en && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_hazard();
        test_set_wins();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
